// File: rtl/inst_buffer_pkg.sv
// Shared constants for the IF1 -> ID instruction buffer.
// Entry layout: {pc_valid, pc_is_jump, pc[31:0], inst[31:0]}.
package inst_buffer_pkg;
  localparam int IB_WIDTH      = 16;
  localparam int IB_WIDTH_LOG2 = 4;
  localparam int IB_PTR_WD     = IB_WIDTH_LOG2 + 1;
  localparam int IB_DATA_WD    = 66;
  localparam int IB_PUSH_SLOTS = 4;
  localparam int IB_POP_SLOTS  = 2;

  localparam int IB_INST_LSB   = 0;
  localparam int IB_PC_LSB     = 32;
  localparam int IB_PC_IS_JUMP = 64;
  localparam int IB_PC_VALID   = 65;
endpackage

// File: rtl/ib_entry_array.sv
// Instruction buffer storage: IB_WIDTH x IB_DATA_WD registers, 4 write ports, 2 async reads.
module ib_entry_array
  import inst_buffer_pkg::*;
(
  input  logic                                    clk,
  input  logic [IB_PUSH_SLOTS-1:0]                we,
  input  logic [IB_PUSH_SLOTS*IB_WIDTH_LOG2-1:0]  waddr,
  input  logic [IB_PUSH_SLOTS*IB_DATA_WD-1:0]     wdata,
  input  logic [IB_POP_SLOTS*IB_WIDTH_LOG2-1:0]   raddr,
  output logic [IB_POP_SLOTS*IB_DATA_WD-1:0]      rdata
);

  logic [IB_DATA_WD-1:0] mem [IB_WIDTH];

  // Write addresses are always consecutive, so ports never collide.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IB_PUSH_SLOTS; k++) begin
      if (we[k]) mem[waddr[k*IB_WIDTH_LOG2 +: IB_WIDTH_LOG2]] <= wdata[k*IB_DATA_WD +: IB_DATA_WD];
    end
  end

  for (genvar r = 0; r < IB_POP_SLOTS; r++) begin : g_rd
    assign rdata[r*IB_DATA_WD +: IB_DATA_WD] = mem[raddr[r*IB_WIDTH_LOG2 +: IB_WIDTH_LOG2]];
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer between IF1 and ID: push 0..4, present/pop up to 2 per cycle.
// Optional IB_BYPASS_EN: forward IF1 slots straight to ID when the buffer is empty.
module inst_buffer
  import inst_buffer_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush_IB,
  input  logic [IB_PUSH_SLOTS*IB_DATA_WD-1:0]  if1_to_ib,
  input  logic [2:0]                           push_num,
  output logic [IB_WIDTH_LOG2:0]               can_push_size,
  output logic [IB_POP_SLOTS*IB_DATA_WD-1:0]   ib_to_id,
  output logic [1:0]                           ib_valid_num,
  input  logic [1:0]                           pop_num
);

  localparam logic [IB_PTR_WD-1:0] IB_FULL = IB_PTR_WD'(IB_WIDTH);

  logic [IB_PTR_WD-1:0]   head, tail, head_nxt, tail_nxt, count;
  logic                   push_legal, push_drop, bypass_act;
  logic [2:0]             push_amt;
  logic [1:0]             stored_vn, push_vn, valid_num, eff_pop, shift;
  logic [IB_DATA_WD-1:0]  in_slot [IB_PUSH_SLOTS];

  logic [IB_PUSH_SLOTS-1:0]                we;
  logic [IB_PUSH_SLOTS*IB_WIDTH_LOG2-1:0]  waddr;
  logic [IB_PUSH_SLOTS*IB_DATA_WD-1:0]     wdata;
  logic [IB_POP_SLOTS*IB_WIDTH_LOG2-1:0]   raddr;
  logic [IB_POP_SLOTS*IB_DATA_WD-1:0]      rdata;

  for (genvar k = 0; k < IB_PUSH_SLOTS; k++) begin : g_in
    assign in_slot[k] = if1_to_ib[k*IB_DATA_WD +: IB_DATA_WD];
  end

  assign count         = tail - head;
  assign can_push_size = IB_FULL - count;

`ifdef IB_BYPASS_EN
  assign bypass_act = (count == '0) && !flush_IB;
`else
  assign bypass_act = 1'b0;
`endif

  // Oversized pushes are dropped whole; IF1 is expected to respect can_push_size.
  always_comb begin
    push_legal = (push_num <= 3'd4) && ({2'b00, push_num} <= can_push_size);
    push_drop  = !flush_IB && (push_num != 3'd0) && !push_legal;
    push_amt   = (push_legal && !flush_IB) ? push_num : 3'd0;
    stored_vn  = (count >= IB_PTR_WD'(2)) ? 2'd2 : count[1:0];
    push_vn    = 2'd0;
    if (push_legal) push_vn = (push_num >= 3'd2) ? 2'd2 : push_num[1:0];
    valid_num  = bypass_act ? push_vn : stored_vn;
    eff_pop    = (pop_num > valid_num) ? valid_num : pop_num;
    shift      = bypass_act ? eff_pop : 2'd0;
    tail_nxt   = tail + IB_PTR_WD'(push_amt) - IB_PTR_WD'(shift);
    head_nxt   = bypass_act ? head : head + IB_PTR_WD'(eff_pop);
  end

  // Forwarded entries consumed by ID are skipped, so write port k takes slot k+shift.
  for (genvar k = 0; k < IB_PUSH_SLOTS; k++) begin : g_wr
    logic [2:0] src;
    assign src = 3'(k) + {1'b0, shift};
    assign we[k] = !flush_IB && push_legal && (src < push_num);
    assign wdata[k*IB_DATA_WD +: IB_DATA_WD] = (src < 3'd4) ? in_slot[src[1:0]] : '0;
    assign waddr[k*IB_WIDTH_LOG2 +: IB_WIDTH_LOG2] = tail[IB_WIDTH_LOG2-1:0] + IB_WIDTH_LOG2'(k);
  end

  assign raddr = {head[IB_WIDTH_LOG2-1:0] + IB_WIDTH_LOG2'(1), head[IB_WIDTH_LOG2-1:0]};

  ib_entry_array u_entry_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (flush_IB) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end

  assign ib_valid_num = valid_num;
  assign ib_to_id[0 +: IB_DATA_WD] = (valid_num != 2'd0) ?
      (bypass_act ? in_slot[0] : rdata[0 +: IB_DATA_WD]) : '0;
  assign ib_to_id[IB_DATA_WD +: IB_DATA_WD] = (valid_num == 2'd2) ?
      (bypass_act ? in_slot[1] : rdata[IB_DATA_WD +: IB_DATA_WD]) : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!push_drop)
        else $warning("inst_buffer: IF1 push of %0d exceeds free space %0d, push dropped",
                      push_num, can_push_size);
    end
  end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer; expected entries queued on push, compared as ID sees them.
module tb_inst_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_IB;
  logic [263:0] if1_to_ib;
  logic [2:0]   push_num;
  logic [4:0]   can_push_size;
  logic [131:0] ib_to_id;
  logic [1:0]   ib_valid_num;
  logic [1:0]   pop_num;

  int n_test = 0;
  int n_fail = 0;
  logic [65:0] mq [$];

  inst_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_IB      (flush_IB),
    .if1_to_ib     (if1_to_ib),
    .push_num      (push_num),
    .can_push_size (can_push_size),
    .ib_to_id      (ib_to_id),
    .ib_valid_num  (ib_valid_num),
    .pop_num       (pop_num)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_test++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [65:0] ent(input logic [31:0] pc);
    return {1'b1, 1'b0, pc, pc ^ 32'hdeadbeef};
  endfunction

  function automatic logic [263:0] pack4(input logic [31:0] pc);
    return {ent(pc + 32'd12), ent(pc + 32'd8), ent(pc + 32'd4), ent(pc)};
  endfunction

  // One cycle: drive at negedge, check combinational outputs, update model, wait for edge.
  task automatic step(input logic [2:0] pn, input logic [1:0] pp, input logic fl,
                      input logic [263:0] slots);
    int cnt, cps, vn, ep;
    logic legal, byp;
    logic [65:0] e0, e1, s [4];
    @(negedge clk);
    push_num = pn; pop_num = pp; flush_IB = fl; if1_to_ib = slots;
    #1;
    for (int k = 0; k < 4; k++) s[k] = slots[k*66 +: 66];
    cnt   = mq.size();
    cps   = 16 - cnt;
    legal = (pn <= 3'd4) && (int'(pn) <= cps);
    byp   = 1'b0;
`ifdef IB_BYPASS_EN
    byp   = (cnt == 0) && !fl;
`endif
    if (byp) begin
      vn = legal ? ((pn >= 3'd2) ? 2 : int'(pn)) : 0;
      e0 = (vn > 0) ? s[0] : '0;
      e1 = (vn > 1) ? s[1] : '0;
    end else begin
      vn = (cnt >= 2) ? 2 : cnt;
      e0 = (cnt > 0) ? mq[0] : '0;
      e1 = (cnt > 1) ? mq[1] : '0;
    end
    chk("can_push_size", can_push_size, cps);
    chk("ib_valid_num", ib_valid_num, vn);
    chk("slot0", ib_to_id[65:0], e0);
    chk("slot1", ib_to_id[131:66], e1);
    chk("push_drop", dut.push_drop, !fl && (pn != 3'd0) && !legal);
    if (fl) mq.delete();
    else begin
      ep = (int'(pp) > vn) ? vn : int'(pp);
      if (byp) begin
        if (legal) for (int k = ep; k < int'(pn); k++) mq.push_back(s[k]);
      end else begin
        repeat (ep) void'(mq.pop_front());
        if (legal) for (int k = 0; k < int'(pn); k++) mq.push_back(s[k]);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic [263:0] rs;
    rst_n = 1'b0; flush_IB = 1'b0; push_num = '0; pop_num = '0; if1_to_ib = '0;
    #12;
    chk("rst_can_push", can_push_size, 5'd16);
    chk("rst_valid", ib_valid_num, 2'd0);
    chk("rst_id", ib_to_id, '0);
    @(negedge clk); rst_n = 1'b1;

    // basic push of 3, visible next cycle
    step(3'd3, 2'd0, 1'b0, pack4(32'h1c000000));
    step(3'd0, 2'd0, 1'b0, '0);
    chk("t1_pc0", ib_to_id[63:32], 32'h1c000000);

    // fill, overflow drop, pop frees space a cycle later
    step(3'd0, 2'd0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(3'd4, 2'd0, 1'b0, pack4(32'h2000_0000 + 32'(i*16)));
    step(3'd1, 2'd0, 1'b0, pack4(32'h2fff_0000));
    step(3'd0, 2'd2, 1'b0, '0);
    step(3'd0, 2'd0, 1'b0, '0);

    // wrap: park pointers at 14, push A..D straddling the end
    step(3'd0, 2'd0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(3'd4, 2'd0, 1'b0, pack4(32'h3000_0000 + 32'(i*16)));
    step(3'd2, 2'd0, 1'b0, pack4(32'h3000_0030));
    for (int i = 0; i < 7; i++) step(3'd0, 2'd2, 1'b0, '0);
    step(3'd4, 2'd0, 1'b0, pack4(32'hA000_0000));
    step(3'd0, 2'd2, 1'b0, '0);
    step(3'd0, 2'd2, 1'b0, '0);
    step(3'd0, 2'd0, 1'b0, '0);

    // simultaneous push 4 + pop 2 at count 5
    step(3'd4, 2'd0, 1'b0, pack4(32'h4000_0000));
    step(3'd1, 2'd0, 1'b0, pack4(32'h4000_0010));
    step(3'd4, 2'd2, 1'b0, pack4(32'h4000_0020));
    step(3'd0, 2'd0, 1'b0, '0);

    // pop 2 with only one entry
    step(3'd0, 2'd0, 1'b1, '0);
    step(3'd1, 2'd0, 1'b0, pack4(32'h5000_0000));
    step(3'd0, 2'd2, 1'b0, '0);
    step(3'd0, 2'd0, 1'b0, '0);

    // flush with a concurrent push, then push+pop into an empty buffer
    step(3'd4, 2'd0, 1'b0, pack4(32'h6000_0000));
    step(3'd2, 2'd0, 1'b0, pack4(32'h6000_0010));
    step(3'd4, 2'd1, 1'b1, pack4(32'h6000_0020));
    step(3'd0, 2'd0, 1'b0, '0);
    step(3'd3, 2'd2, 1'b0, pack4(32'h7000_0000));
    step(3'd0, 2'd0, 1'b0, '0);

    // random traffic, mostly legal pushes
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++)
        rs[k*66 +: 66] = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom(), $urandom()};
      step(($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
           2'($urandom_range(0, 3)), $urandom_range(0, 40) == 0, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
